cpu_bus_arb: RTL and testbench



---
 rtl/cpu_bus_arb.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_bus_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: multi-master CPU bus arbiter with a three-state sequencer
// (IDLE -> ACCESS -> DONE), fixed-priority or round-robin selection, bus lock,
// and a one-hot 8-region select decoded from the top three address bits.
// Optional lock watchdog: define CPU_BUS_ARB_TIMEOUT_EN to enable it.
module cpu_bus_arb #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int RR_MODE     = 0,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                          clk_in,
   input  logic                          nres_in,
   input  logic [NUM_MASTERS-1:0]        req_in,
   input  logic [NUM_MASTERS-1:0]        lock_in,
   input  logic [NUM_MASTERS*ADDR_W-1:0] a_in,
   input  logic [NUM_MASTERS-1:0]        r_nw_in,
   input  logic [NUM_MASTERS*DATA_W-1:0] d_in,
   output logic [NUM_MASTERS-1:0]        gnt_out,
   output logic [NUM_MASTERS-1:0]        rdy_out,
   output logic [DATA_W-1:0]             d_out,
   output logic [ADDR_W-1:0]             bus_a_out,
   output logic                          bus_r_nw_out,
   output logic [DATA_W-1:0]             bus_d_out,
   output logic                          bus_en_out,
   output logic [7:0]                    sel_out,
   input  logic [8*DATA_W-1:0]           slv_d_in,
   output logic                          timeout_out
);

   // Index width; kept at least 1 so an illegal NUM_MASTERS still reaches the error below
   localparam int PW = (NUM_MASTERS > 2) ? 2 : 1;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_masters
      $error("cpu_bus_arb: NUM_MASTERS must be in the range 2..4");
   end
   if (ADDR_W < 3 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("cpu_bus_arb: ADDR_W must be >= 3 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_r;
   logic [PW-1:0]     win_r;
   logic [PW-1:0]     ptr_r;
   logic [PW-1:0]     base_s;
   logic [PW-1:0]     pick_s;
   logic [PW-1:0]     load_idx_s;
   logic [PW-1:0]     ptr_next_s;
   logic [ADDR_W-1:0] load_a_s;
   logic              any_s;
   logic              relock_s;
   logic              forced_s;

   function automatic logic [NUM_MASTERS-1:0] grant_vec(input logic [PW-1:0] idx);
      logic [NUM_MASTERS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] region_sel(input logic [2:0] region);
      return 8'd1 << region;
   endfunction

   // Fixed priority always searches from master 0; round-robin from the pointer
   assign base_s     = (RR_MODE != 0) ? ptr_r : '0;
   assign any_s      = |req_in;
   // A relocked access re-reads the current winner's request lines
   assign load_idx_s = (state_r == DONE) ? win_r : pick_s;
   assign load_a_s   = a_in[int'(load_idx_s)*ADDR_W +: ADDR_W];
   assign relock_s   = lock_in[win_r] & req_in[win_r] & ~forced_s;
   assign ptr_next_s = (int'(win_r) == NUM_MASTERS-1) ? '0 : win_r + PW'(1);

   // Winner search: walk backwards so the first requester at/after the base is written last
   always_comb begin
      logic [PW-1:0] idx;
      pick_s = '0;
      idx    = '0;
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
         idx = PW'((int'(base_s) + i) % NUM_MASTERS);
         if (req_in[idx]) begin
            pick_s = idx;
         end else begin
            pick_s = pick_s;
         end
      end
   end

   // Sequencer: arbitrate in IDLE, drive the slave bus in ACCESS, complete in DONE
   always_ff @(posedge clk_in or negedge nres_in) begin
      if (!nres_in) begin
         state_r      <= IDLE;
         win_r        <= '0;
         ptr_r        <= '0;
         gnt_out      <= '0;
         rdy_out      <= '0;
         d_out        <= '0;
         bus_a_out    <= '0;
         bus_r_nw_out <= 1'b1;
         bus_d_out    <= '0;
         bus_en_out   <= 1'b0;
         sel_out      <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               rdy_out <= '0;
               if (any_s) begin
                  state_r      <= ACCESS;
                  win_r        <= pick_s;
                  gnt_out      <= grant_vec(pick_s);
                  bus_a_out    <= load_a_s;
                  bus_r_nw_out <= r_nw_in[load_idx_s];
                  bus_d_out    <= d_in[int'(load_idx_s)*DATA_W +: DATA_W];
                  bus_en_out   <= 1'b1;
                  sel_out      <= region_sel(load_a_s[ADDR_W-1 -: 3]);
               end else begin
                  gnt_out    <= '0;
                  bus_en_out <= 1'b0;
                  sel_out    <= 8'h00;
               end
            end
            ACCESS: begin
               state_r    <= DONE;
               bus_en_out <= 1'b0;
               sel_out    <= 8'h00;
               rdy_out    <= grant_vec(win_r);
               // Only the region addressed during ACCESS feeds the read data
               if (bus_r_nw_out) begin
                  d_out <= slv_d_in[int'(bus_a_out[ADDR_W-1 -: 3])*DATA_W +: DATA_W];
               end else begin
                  d_out <= d_out;
               end
            end
            DONE: begin
               rdy_out <= '0;
               if (relock_s) begin
                  state_r      <= ACCESS;
                  bus_a_out    <= load_a_s;
                  bus_r_nw_out <= r_nw_in[load_idx_s];
                  bus_d_out    <= d_in[int'(load_idx_s)*DATA_W +: DATA_W];
                  bus_en_out   <= 1'b1;
                  sel_out      <= region_sel(load_a_s[ADDR_W-1 -: 3]);
               end else begin
                  state_r <= IDLE;
                  gnt_out <= '0;
                  if (RR_MODE != 0) begin
                     ptr_r <= ptr_next_s;
                  end else begin
                     ptr_r <= ptr_r;
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               gnt_out    <= '0;
               rdy_out    <= '0;
               bus_en_out <= 1'b0;
               sel_out    <= 8'h00;
            end
         endcase
      end
   end

`ifdef CPU_BUS_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 2);

   logic [WW-1:0] wd_r;
   logic          to_r;

   // Watchdog: count cycles one grant is held; flag the limit as DONE is entered
   always_ff @(posedge clk_in or negedge nres_in) begin
      if (!nres_in) begin
         wd_r <= '0;
         to_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               wd_r <= any_s ? WW'(1) : '0;
               to_r <= 1'b0;
            end
            ACCESS: begin
               wd_r <= wd_r + WW'(1);
               to_r <= ((int'(wd_r) + 1) >= TIMEOUT_CYC);
            end
            DONE: begin
               if (relock_s) begin
                  wd_r <= wd_r + WW'(1);
               end else begin
                  wd_r <= '0;
               end
               to_r <= 1'b0;
            end
            default: begin
               wd_r <= '0;
               to_r <= 1'b0;
            end
         endcase
      end
   end

   assign forced_s    = to_r;
   assign timeout_out = to_r;
`else
   assign forced_s    = 1'b0;
   assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Bench for cpu_bus_arb: one fixed-priority and one round-robin instance share
// the same stimulus; a transaction-level model predicts winners, bus contents,
// completion pulses and read data.
module tb_cpu_bus_arb;
   localparam int NM = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic nres_in = 1'b1;
   logic [NM-1:0]    req = '0;
   logic [NM-1:0]    lock = '0;
   logic [NM-1:0]    rnw = '0;
   logic [NM*AW-1:0] a_bus = '0;
   logic [NM*DW-1:0] d_bus = '0;
   logic [8*DW-1:0]  slv_bus = '0;

   logic [NM-1:0] fp_gnt, fp_rdy, rr_gnt, rr_rdy;
   logic [DW-1:0] fp_dout, rr_dout, fp_bd, rr_bd;
   logic [AW-1:0] fp_ba, rr_ba;
   logic          fp_brnw, rr_brnw, fp_ben, rr_ben, fp_to, rr_to;
   logic [7:0]    fp_sel, rr_sel;

   logic [AW-1:0] addr [NM];
   logic [DW-1:0] wdat [NM];
   logic [DW-1:0] slv  [8];

   int n_tests = 0;
   int n_fail  = 0;
   int m_ptr   = 0;
   logic [DW-1:0] m_dout_fp = '0;
   logic [DW-1:0] m_dout_rr = '0;

   cpu_bus_arb #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT_CYC(TO)) u_fp (
      .clk_in(clk), .nres_in(nres_in), .req_in(req), .lock_in(lock), .a_in(a_bus),
      .r_nw_in(rnw), .d_in(d_bus), .gnt_out(fp_gnt), .rdy_out(fp_rdy), .d_out(fp_dout),
      .bus_a_out(fp_ba), .bus_r_nw_out(fp_brnw), .bus_d_out(fp_bd), .bus_en_out(fp_ben),
      .sel_out(fp_sel), .slv_d_in(slv_bus), .timeout_out(fp_to));

   cpu_bus_arb #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT_CYC(TO)) u_rr (
      .clk_in(clk), .nres_in(nres_in), .req_in(req), .lock_in(lock), .a_in(a_bus),
      .r_nw_in(rnw), .d_in(d_bus), .gnt_out(rr_gnt), .rdy_out(rr_rdy), .d_out(rr_dout),
      .bus_a_out(rr_ba), .bus_r_nw_out(rr_brnw), .bus_d_out(rr_bd), .bus_en_out(rr_ben),
      .sel_out(rr_sel), .slv_d_in(slv_bus), .timeout_out(rr_to));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      for (int i = 0; i < NM; i++) begin
         a_bus[i*AW +: AW] = addr[i];
         d_bus[i*DW +: DW] = wdat[i];
      end
      for (int j = 0; j < 8; j++) slv_bus[j*DW +: DW] = slv[j];
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NM; i++) begin
         addr[i] = AW'($urandom);
         wdat[i] = DW'($urandom);
      end
      rnw = NM'($urandom);
      for (int j = 0; j < 8; j++) slv[j] = DW'($urandom);
      apply();
   endtask

   // Lowest-numbered requester
   function automatic int pick_fixed(input logic [NM-1:0] r);
      for (int i = 0; i < NM; i++) if (r[i]) return i;
      return 0;
   endfunction

   // First requester in the rotated order p, p+1, ... (mod NM)
   function automatic int pick_rr(input logic [NM-1:0] r, input int p);
      int q[$];
      for (int k = 0; k < NM; k++) q.push_back((p + k) % NM);
      foreach (q[k]) if (r[q[k]]) return q[k];
      return 0;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_fp_gnt"}, fp_gnt, 0);  chk({tag, "_rr_gnt"}, rr_gnt, 0);
      chk({tag, "_fp_rdy"}, fp_rdy, 0);  chk({tag, "_rr_rdy"}, rr_rdy, 0);
      chk({tag, "_fp_ben"}, fp_ben, 0);  chk({tag, "_rr_ben"}, rr_ben, 0);
      chk({tag, "_fp_sel"}, fp_sel, 0);  chk({tag, "_rr_sel"}, rr_sel, 0);
      chk({tag, "_fp_to"},  fp_to, 0);   chk({tag, "_rr_to"},  rr_to, 0);
      chk({tag, "_fp_ba"},  fp_ba, 0);   chk({tag, "_rr_ba"},  rr_ba, 0);
      chk({tag, "_fp_bd"},  fp_bd, 0);   chk({tag, "_rr_bd"},  rr_bd, 0);
      chk({tag, "_fp_dout"}, fp_dout, 0); chk({tag, "_rr_dout"}, rr_dout, 0);
      chk({tag, "_fp_brnw"}, fp_brnw, 1); chk({tag, "_rr_brnw"}, rr_brnw, 1);
   endtask

   // One unlocked transfer starting from IDLE: grant, bus cycle, completion, release
   task automatic do_xfer(input logic [NM-1:0] r);
      int wf, wr;
      logic [2:0] rf, rg;
      req  = r;
      lock = '0;
      wf = pick_fixed(r);
      wr = pick_rr(r, m_ptr);
      rf = addr[wf][AW-1 -: 3];
      rg = addr[wr][AW-1 -: 3];
      tick();
      chk("fp_gnt", fp_gnt, 64'(1) << wf);       chk("rr_gnt", rr_gnt, 64'(1) << wr);
      chk("fp_ben", fp_ben, 1);                  chk("rr_ben", rr_ben, 1);
      chk("fp_bus_a", fp_ba, addr[wf]);          chk("rr_bus_a", rr_ba, addr[wr]);
      chk("fp_bus_rnw", fp_brnw, rnw[wf]);       chk("rr_bus_rnw", rr_brnw, rnw[wr]);
      chk("fp_bus_d", fp_bd, wdat[wf]);          chk("rr_bus_d", rr_bd, wdat[wr]);
      chk("fp_sel", fp_sel, 64'(1) << rf);       chk("rr_sel", rr_sel, 64'(1) << rg);
      chk("fp_rdy_early", fp_rdy, 0);            chk("rr_rdy_early", rr_rdy, 0);
      tick();
      if (rnw[wf]) m_dout_fp = slv[rf];
      if (rnw[wr]) m_dout_rr = slv[rg];
      chk("fp_rdy", fp_rdy, 64'(1) << wf);       chk("rr_rdy", rr_rdy, 64'(1) << wr);
      chk("fp_dout", fp_dout, m_dout_fp);        chk("rr_dout", rr_dout, m_dout_rr);
      chk("fp_ben_done", fp_ben, 0);             chk("rr_ben_done", rr_ben, 0);
      chk("fp_sel_done", fp_sel, 0);             chk("rr_sel_done", rr_sel, 0);
      chk("fp_to_done", fp_to, 0);               chk("rr_to_done", rr_to, 0);
      tick();
      chk("fp_gnt_rel", fp_gnt, 0);              chk("rr_gnt_rel", rr_gnt, 0);
      chk("fp_rdy_rel", fp_rdy, 0);              chk("rr_rdy_rel", rr_rdy, 0);
      m_ptr = (wr + 1) % NM;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      bit done;
      bit exp_to;

      // Reset values
      rand_inputs();
      #1 nres_in = 1'b0;
      repeat (3) tick();
      chk_reset("rst");

      // Single read: master 0 reads 0x0005, region 0 holds 0x3C
      rand_inputs();
      addr[0] = 16'h0005; rnw[0] = 1'b1; slv[0] = 8'h3C;
      apply();
      req = 3'b001;
      @(negedge clk);
      nres_in = 1'b1;
      do_xfer(3'b001);
      chk("single_read_dout", fp_dout, 8'h3C);

      // Simultaneous requests, then the loser alone
      rand_inputs();
      do_xfer(3'b011);
      do_xfer(3'b010);

      // Continuous requests from masters 0 and 1
      for (int k = 0; k < 6; k++) begin
         rand_inputs();
         do_xfer(3'b011);
      end

      // Random request patterns
      for (int k = 0; k < 24; k++) begin
         rand_inputs();
         do_xfer(NM'($urandom_range(1, 7)));
      end

      // Lock: master 1 does three writes to 0x2001 while master 0 waits
      rand_inputs();
      addr[1] = 16'h2001; rnw[1] = 1'b0; rnw[0] = 1'b1;
      apply();
      req = 3'b010; lock = 3'b010;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lk_fp_gnt", fp_gnt, 3'b010);   chk("lk_rr_gnt", rr_gnt, 3'b010);
         chk("lk_fp_ben", fp_ben, 1);        chk("lk_rr_ben", rr_ben, 1);
         chk("lk_fp_ba", fp_ba, 16'h2001);   chk("lk_fp_brnw", fp_brnw, 0);
         chk("lk_fp_bd", fp_bd, wdat[1]);    chk("lk_fp_sel", fp_sel, 8'h02);
         chk("lk_fp_rdy0", fp_rdy, 0);
         tick();
         chk("lk_fp_gnt_d", fp_gnt, 3'b010); chk("lk_rr_gnt_d", rr_gnt, 3'b010);
         chk("lk_fp_rdy", fp_rdy, 3'b010);   chk("lk_rr_rdy", rr_rdy, 3'b010);
         chk("lk_fp_dout", fp_dout, m_dout_fp); chk("lk_rr_dout", rr_dout, m_dout_rr);
         chk("lk_fp_to", fp_to, 0);
         if (k == 0) req = 3'b011;
      end
      lock = '0;
      req  = 3'b001;
      tick();
      chk("lk_fp_rel", fp_gnt, 0);            chk("lk_rr_rel", rr_gnt, 0);
      m_ptr = 2;
      do_xfer(3'b001);

      // Master 0 holds the lock; watchdog behaviour depends on the build
      rand_inputs();
      req = 3'b001; lock = 3'b001;
      c = 0; done = 1'b0;
      while (!done && c < 40) begin
         tick();
         c++;
         if (c == 1) req = 3'b011;
         chk("hold_fp_gnt", fp_gnt, 3'b001); chk("hold_rr_gnt", rr_gnt, 3'b001);
         chk("hold_fp_ben", fp_ben, (c % 2) == 1);
         chk("hold_fp_rdy", fp_rdy, ((c % 2) == 0) ? 3'b001 : 3'b000);
         if ((c % 2) == 0 && rnw[0]) begin
            m_dout_fp = slv[addr[0][AW-1 -: 3]];
            m_dout_rr = m_dout_fp;
         end
         if ((c % 2) == 1) chk("hold_fp_ba", fp_ba, addr[0]);
         chk("hold_fp_dout", fp_dout, m_dout_fp);
         exp_to = 1'b0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
         exp_to = ((c % 2) == 0) && (c >= TO);
         if (exp_to) done = 1'b1;
`else
         if (c == 20) done = 1'b1;
`endif
         chk("hold_fp_to", fp_to, exp_to);   chk("hold_rr_to", rr_to, exp_to);
      end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
      chk("hold_forced_release", done, 1);
`endif
      lock = '0;
      tick();
      chk("hold_fp_rel", fp_gnt, 0);          chk("hold_rr_rel", rr_gnt, 0);
      chk("hold_fp_to_rel", fp_to, 0);
      m_ptr = 1;
      do_xfer(3'b011);

      // Reset in the middle of an access
      rand_inputs();
      rnw[0] = 1'b1;
      req = 3'b001;
      tick();
      chk("mid_fp_ben", fp_ben, 1);           chk("mid_rr_ben", rr_ben, 1);
      #2 nres_in = 1'b0;
      #1 chk_reset("mid_rst");
      req = '0;
      @(negedge clk);
      nres_in = 1'b1;
      m_ptr = 0; m_dout_fp = '0; m_dout_rr = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_fp_rdy", fp_rdy, 0);       chk("post_rr_rdy", rr_rdy, 0);
         chk("post_fp_gnt", fp_gnt, 0);       chk("post_rr_gnt", rr_gnt, 0);
      end
      rand_inputs();
      do_xfer(3'b110);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
